// File: rtl/nonce_scheduler.sv
// Nonce issue/tracking controller for the double-SHA256 finisher datapath.
// Define NONCE_SCHED_STATS_EN to add hash_count/share_count statistics outputs.
module nonce_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_tail,
    input  logic [31:0]  work_nonce_start,
    input  logic [31:0]  work_nonce_end,
    input  logic         abort,
    output logic [255:0] core_x,
    output logic [95:0]  core_y,
    output logic [31:0]  core_nonce,
    output logic         core_nonce_valid,
    input  logic         core_take,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic         work_done,
    output logic         overflow
`ifdef NONCE_SCHED_STATS_EN
   ,output logic [31:0]  hash_count,
    output logic [15:0]  share_count
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [255:0]       r_x;
    logic [95:0]        r_y;
    logic [31:0]        r_nonce;
    logic [31:0]        r_end;
    logic               r_discard;
    logic [31:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W:0]     w_count_nxt;
    logic               r_found_valid;
    logic [31:0]        r_found_nonce;
    logic               r_work_done;
    logic               w_work_done_nxt;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               w_share;
    logic               w_load_found;

    assign w_full       = (r_count == CntFull);
    assign w_empty      = (r_count == '0);
    assign w_valid      = (r_state == StRun) && !w_full;
    assign w_push       = core_take && w_valid;
    assign w_pop        = core_done && !w_empty;
    assign w_last       = (r_nonce == r_end);
    assign w_share      = w_pop && !r_discard && (core_hash[255:224] == 32'h0);
    assign w_load_found = w_share && (!r_found_valid || found_ready);
    assign w_count_nxt  = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

    always_comb begin
        w_state_nxt     = r_state;
        w_work_done_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (work_valid) w_state_nxt = StRun;
            end
            StRun: begin
                if (abort || (w_push && w_last)) w_state_nxt = StDrain;
            end
            StDrain: begin
                // Leave as soon as the last in-flight result pops, so work_done trails it by one
                if (w_count_nxt == '0) begin
                    w_state_nxt     = StIdle;
                    w_work_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_x           <= '0;
            r_y           <= '0;
            r_nonce       <= '0;
            r_end         <= '0;
            r_discard     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_found_valid <= 1'b0;
            r_found_nonce <= '0;
            r_work_done   <= 1'b0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_work_done <= w_work_done_nxt;
            r_count     <= w_count_nxt;

            if (r_state == StIdle && work_valid) begin
                r_x     <= work_midstate;
                r_y     <= work_tail;
                r_nonce <= work_nonce_start;
                r_end   <= work_nonce_end;
            end else if (w_push && !w_last) begin
                r_nonce <= r_nonce + 32'd1;
            end

            if (r_state == StIdle) r_discard <= 1'b0;
            else if (abort)        r_discard <= 1'b1;

            if (w_push) begin
                r_mem[r_wr_ptr] <= r_nonce;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            if (w_load_found) begin
                r_found_valid <= 1'b1;
                r_found_nonce <= r_mem[r_rd_ptr];
            end else if (r_found_valid && found_ready) begin
                r_found_valid <= 1'b0;
            end
            if (w_share && !w_load_found) r_overflow <= 1'b1;
        end
    end

`ifdef NONCE_SCHED_STATS_EN
    logic [31:0] r_hash_count;
    logic [15:0] r_share_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hash_count  <= '0;
            r_share_count <= '0;
        end else begin
            if (w_pop)   r_hash_count  <= r_hash_count + 32'd1;
            if (w_share) r_share_count <= r_share_count + 16'd1;
        end
    end

    assign hash_count  = r_hash_count;
    assign share_count = r_share_count;
`endif

    assign work_ready       = (r_state == StIdle);
    assign core_x           = r_x;
    assign core_y           = r_y;
    assign core_nonce       = r_nonce;
    assign core_nonce_valid = w_valid;
    assign found_valid      = r_found_valid;
    assign found_nonce      = r_found_nonce;
    assign work_done        = r_work_done;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: vector table plus corner-case sequences,
// with a queue scoreboard of in-flight nonces.
module tb_nonce_scheduler;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_tail;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic         abort;
    logic [255:0] core_x;
    logic [95:0]  core_y;
    logic [31:0]  core_nonce;
    logic         core_nonce_valid;
    logic         core_take;
    logic         core_done;
    logic [255:0] core_hash;
    logic         found_valid;
    logic         found_ready;
    logic [31:0]  found_nonce;
    logic         work_done;
    logic         overflow;
`ifdef NONCE_SCHED_STATS_EN
    logic [31:0]  hash_count;
    logic [15:0]  share_count;
`endif

    always #5 clk = ~clk;

    nonce_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .work_valid       (work_valid),
        .work_ready       (work_ready),
        .work_midstate    (work_midstate),
        .work_tail        (work_tail),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
        .abort            (abort),
        .core_x           (core_x),
        .core_y           (core_y),
        .core_nonce       (core_nonce),
        .core_nonce_valid (core_nonce_valid),
        .core_take        (core_take),
        .core_done        (core_done),
        .core_hash        (core_hash),
        .found_valid      (found_valid),
        .found_ready      (found_ready),
        .found_nonce      (found_nonce),
        .work_done        (work_done),
`ifdef NONCE_SCHED_STATS_EN
        .hash_count       (hash_count),
        .share_count      (share_count),
`endif
        .overflow         (overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef enum {MIdle, MRun, MDrain} mstate_t;
    mstate_t     m_state;
    logic [31:0] m_next, m_end, m_fn;
    logic [31:0] m_q[$];
    bit          m_discard, m_fv, m_ovf, m_wd;
    int          d_pushes, d_found;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] share;
        int          n;
        int          nfound;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = MIdle; m_next = '0; m_end = '0; m_fn = '0;
        m_q.delete();
        m_discard = 0; m_fv = 0; m_ovf = 0; m_wd = 0;
    endtask

    // Entered and left at a falling edge; drives one cycle and checks the result.
    task automatic step(input bit take, input bit done, input bit share, input bit ready,
                        input bit abrt);
        bit          valid, push, pop, sh;
        logic [31:0] n;
        logic [255:0] h;
        mstate_t     ns;
        valid = (m_state == MRun) && (m_q.size() < DEPTH);
        chk("core_nonce_valid", core_nonce_valid, valid);
        if (valid) chk("core_nonce", core_nonce, m_next);
        if (core_nonce_valid && take) d_pushes++;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom();
        if (share) h[255:224] = 32'h0;
        else if (h[255:224] == 32'h0) h[255:224] = 32'h1;
        core_take = take; core_done = done; core_hash = h;
        found_ready = ready; abort = abrt;

        push = take && valid;
        pop  = done && (m_q.size() > 0);
        sh   = 0;
        n    = '0;
        if (pop) begin
            n  = m_q.pop_front();
            sh = share && !m_discard;
        end
        if (push) m_q.push_back(m_next);
        ns   = m_state;
        m_wd = 0;
        case (m_state)
            MRun:   if (abrt || (push && m_next == m_end)) ns = MDrain;
            MDrain: if (m_q.size() == 0) begin ns = MIdle; m_wd = 1; end
            default: ;
        endcase
        if (push && m_next != m_end) m_next = m_next + 32'd1;
        if (m_state == MIdle) m_discard = 0;
        else if (abrt)        m_discard = 1;
        if (sh && (!m_fv || ready)) begin
            m_fv = 1; m_fn = n;
        end else begin
            if (sh) m_ovf = 1;
            else if (m_fv && ready) m_fv = 0;
        end
        m_state = ns;

        @(posedge clk);
        @(negedge clk);
        core_take = 0; core_done = 0; abort = 0;
        if (found_valid) d_found++;
        chk("found_valid", found_valid, m_fv);
        chk("found_nonce", found_nonce, m_fn);
        chk("work_done", work_done, m_wd);
        chk("overflow", overflow, m_ovf);
        chk("work_ready", work_ready, m_state == MIdle);
    endtask

    task automatic start_work(input logic [31:0] s, input logic [31:0] e);
        logic [255:0] mid;
        logic [95:0]  tl;
        for (int i = 0; i < 8; i++) mid[i*32 +: 32] = $urandom();
        for (int i = 0; i < 3; i++) tl[i*32 +: 32] = $urandom();
        chk("work_ready_before", work_ready, 1'b1);
        work_valid = 1; work_midstate = mid; work_tail = tl;
        work_nonce_start = s; work_nonce_end = e;
        @(posedge clk);
        @(negedge clk);
        work_valid = 0;
        work_midstate = ~mid; work_tail = ~tl;
        if (m_fv && found_ready) m_fv = 0;
        m_state = MRun; m_next = s; m_end = e; m_discard = 0; m_wd = 0;
        d_pushes = 0; d_found = 0;
        chk("core_x", core_x, mid);
        chk("core_y", core_y, tl);
        chk("work_ready_run", work_ready, 1'b0);
    endtask

    task automatic drain(input bit share);
        for (int k = 0; k < 64 && m_state != MIdle; k++)
            step(0, m_q.size() > 0, share, 1, 0);
        chk("drain_idle", work_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{s: 32'h10,       e: 32'h13,       share: 32'h12,       n: 4, nfound: 1};
        vt[1] = '{s: 32'hFFFFFFFE, e: 32'h00000001, share: 32'h0,        n: 4, nfound: 1};
        vt[2] = '{s: 32'h5,        e: 32'h5,        share: 32'h5,        n: 1, nfound: 1};
        vt[3] = '{s: 32'h100,      e: 32'h107,      share: 32'hDEAD,     n: 8, nfound: 0};

        reset = 1; work_valid = 0; work_midstate = '0; work_tail = '0;
        work_nonce_start = '0; work_nonce_end = '0; abort = 0;
        core_take = 0; core_done = 0; core_hash = '1; found_ready = 1;
        model_reset();
        @(negedge clk);
        chk("rst_work_ready", work_ready, 1'b1);
        chk("rst_core_x", core_x, 256'h0);
        chk("rst_core_y", core_y, 96'h0);
        chk("rst_core_nonce", core_nonce, 32'h0);
        chk("rst_core_nonce_valid", core_nonce_valid, 1'b0);
        chk("rst_found_valid", found_valid, 1'b0);
        chk("rst_found_nonce", found_nonce, 32'h0);
        chk("rst_work_done", work_done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 0;
        @(negedge clk);

        // Table: take every cycle, results return every other cycle
        for (int v = 0; v < 4; v++) begin
            start_work(vt[v].s, vt[v].e);
            for (int k = 0; k < 300 && m_state != MIdle; k++)
                step(1, (k % 2) == 1, (m_q.size() > 0) && (m_q[0] == vt[v].share), 1, 0);
            chk("tbl_pushes", d_pushes, vt[v].n);
            chk("tbl_found", d_found, vt[v].nfound);
            step(0, 0, 0, 1, 0);
        end

        // FIFO full: exactly DEPTH pushes, push+pop keeps occupancy
        start_work(32'h1000, 32'h10FF);
        for (int k = 0; k < 6; k++) step(1, 0, 0, 1, 0);
        chk("full_pushes", d_pushes, DEPTH);
        chk("full_valid_low", core_nonce_valid, 1'b0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("pushpop_valid", core_nonce_valid, 1'b1);
        step(1, 0, 0, 1, 0);
        chk("refull_valid_low", core_nonce_valid, 1'b0);
        step(0, 0, 0, 1, 1);
        drain(1);

        // Two share pops, host ready on the second
        start_work(32'h20, 32'h21);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("ready2_nonce", found_nonce, 32'h21);
        chk("ready2_ovf", overflow, 1'b0);
        step(0, 0, 0, 1, 0);

        // Two share pops, host never ready: second share dropped
        start_work(32'h30, 32'h31);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("ovf_nonce", found_nonce, 32'h30);
        chk("ovf_set", overflow, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("ovf_hold_nonce", found_nonce, 32'h30);
        step(0, 0, 0, 1, 0);

        // Abort with a share pending; a take coinciding with abort still pushes
        start_work(32'h40, 32'h4F);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        chk("abort_pushes", d_pushes, 3);
        step(1, 0, 0, 1, 0);
        drain(1);
        chk("abort_no_found", d_found, 0);

        // Asynchronous reset with nonces in flight
        start_work(32'h50, 32'h5F);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        #2 reset = 1;
        #1;
        chk("arst_core_x", core_x, 256'h0);
        chk("arst_core_nonce", core_nonce, 32'h0);
        chk("arst_valid", core_nonce_valid, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_work_ready", work_ready, 1'b1);
        model_reset();
        @(negedge clk);
        reset = 0;
        d_found = 0;
        for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 0);
        chk("arst_no_found", d_found, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
